// File: rtl/test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : test_pkg
// Description : Shared rule codes and default widths for the priority
//               if-chain classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package test_pkg;

    // Default operand width (must be >= 4, P1 looks at a[3:2]).
    localparam int DEF_W     = 4;
    // Default width of the saturating status-hit counter.
    localparam int DEF_CNT_W = 8;

    // Index of the winning rule, as presented on the code output.
    typedef enum logic [1:0] {
        CODE_NONE = 2'd0,
        CODE_P1   = 2'd1,
        CODE_EQ   = 2'd2,
        CODE_GT   = 2'd3
    } code_e;

endpackage : test_pkg
`default_nettype wire

// File: rtl/test_if.sv
`default_nettype none
// ============================================================================
// Module      : test_if
// Description : Operand/result bundle of the classifier. The master drives
//               in_valid/a/b, the slave (the classifier) returns the
//               registered status, code and hit counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface test_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             status;
    logic [1:0]       code;
    logic [CNT_W-1:0] hit_cnt;

    modport master (
        output in_valid, a, b,
        input  status, code, hit_cnt
    );

    modport slave (
        input  in_valid, a, b,
        output status, code, hit_cnt
    );
endinterface : test_if
`default_nettype wire

// File: rtl/test_classify.sv
`default_nettype none
// ============================================================================
// Module      : test_classify
// Description : Purely combinational priority chain. First match wins:
//               P1 {b[1],a[3:2]}==3'b001, P2 a==b, P3 a>b, else a<b.
// Revision    : 1.0 - initial release
// ============================================================================
module test_classify
    import test_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  wire logic [W-1:0] a_i,
    input  wire logic [W-1:0] b_i,
    output logic              status_o,
    output logic [1:0]        code_o
);

    logic w_p1_match;

    // P1 only looks at three specific bits; it outranks equality on overlap.
    assign w_p1_match = ({b_i[1], a_i[3:2]} == 3'b001);

    // Priority if-chain; defaults cover the a<b fall-through.
    always_comb begin
        status_o = 1'b0;
        code_o   = CODE_NONE;
        if (w_p1_match) begin
            status_o = 1'b1;
            code_o   = CODE_P1;
        end else if (a_i == b_i) begin
            status_o = 1'b1;
            code_o   = CODE_EQ;
        end else if (a_i > b_i) begin
            status_o = 1'b0;
            code_o   = CODE_GT;
        end
    end

endmodule : test_classify
`default_nettype wire

// File: rtl/test.sv
`default_nettype none
// ============================================================================
// Module      : test
// Description : Registered priority classifier. Accepted cycles (in_valid=1)
//               update status/code and a saturating hit counter one edge
//               later; otherwise everything holds. Synchronous active-low
//               reset on rstn.
//               Optional macro TEST_STICKY_STATUS_EN: status, once set,
//               stays 1 until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module test
    import test_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  wire logic clk,
    input  wire logic rstn,
    test_if.slave     bus
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic             w_cls_status;
    logic [1:0]       w_cls_code;

    logic             status_q, status_d;
    logic [1:0]       code_q,   code_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    test_classify #(
        .W (W)
    ) u_classify (
        .a_i      (bus.a),
        .b_i      (bus.b),
        .status_o (w_cls_status),
        .code_o   (w_cls_code)
    );

    // Next-state: hold unless accepted; counter follows the classified hit.
    always_comb begin
        status_d = status_q;
        code_d   = code_q;
        cnt_d    = cnt_q;
        if (bus.in_valid) begin
`ifdef TEST_STICKY_STATUS_EN
            status_d = status_q | w_cls_status;
`else
            status_d = w_cls_status;
`endif
            code_d   = w_cls_code;
            if (w_cls_status && (cnt_q != C_CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Output registers with synchronous active-low reset taking priority.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            status_q <= 1'b0;
            code_q   <= CODE_NONE;
            cnt_q    <= '0;
        end else begin
            status_q <= status_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.status  = status_q;
    assign bus.code    = code_q;
    assign bus.hit_cnt = cnt_q;

endmodule : test
`default_nettype wire

// File: tb/tb_test.sv
`default_nettype none
// ============================================================================
// Module      : tb_test
// Description : Directed self-checking bench for the priority classifier.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    test_if #(.W(4), .CNT_W(8)) bus ();

    test #(
        .W     (4),
        .CNT_W (8)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count it, report a mismatch.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply inputs on the falling edge, then sample 1 ns after the rising edge.
    task automatic step(input logic r, input logic v, input logic [3:0] ai, input logic [3:0] bi);
        @(negedge clk);
        rstn         = r;
        bus.in_valid = v;
        bus.a        = ai;
        bus.b        = bi;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic s, input logic [1:0] c, input logic [7:0] n);
        chk({tag, ".status"},  {31'd0, bus.status}, {31'd0, s});
        chk({tag, ".code"},    {30'd0, bus.code},   {30'd0, c});
        chk({tag, ".hit_cnt"}, {24'd0, bus.hit_cnt}, {24'd0, n});
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rstn         = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = 4'd0;
        bus.b        = 4'd0;

        // Reset wins even with a valid P1 input present.
        step(1'b0, 1'b1, 4'd5, 4'd5);
        chk_all("rst0", 1'b0, 2'd0, 8'd0);
        step(1'b0, 1'b1, 4'd5, 4'd5);
        chk_all("rst1", 1'b0, 2'd0, 8'd0);

        // GT
        step(1'b1, 1'b1, 4'd10, 4'd8);
        chk_all("gt", 1'b0, 2'd3, 8'd0);

        // P1 beats P2 on overlap, then plain equality
        step(1'b1, 1'b1, 4'b0101, 4'b0101);
        chk_all("p1ovl", 1'b1, 2'd1, 8'd1);
        step(1'b1, 1'b1, 4'd8, 4'd8);
        chk_all("eq", 1'b1, 2'd2, 8'd2);

        // Else (a<b)
        step(1'b1, 1'b1, 4'd2, 4'd9);
`ifdef TEST_STICKY_STATUS_EN
        chk_all("lt", 1'b1, 2'd0, 8'd2);
`else
        chk_all("lt", 1'b0, 2'd0, 8'd2);
`endif

        // Hold while in_valid=0
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 4'd8, 4'd8);
`ifdef TEST_STICKY_STATUS_EN
            chk_all("hold", 1'b1, 2'd0, 8'd2);
`else
            chk_all("hold", 1'b0, 2'd0, 8'd2);
`endif
        end

        // P1 despite a>b: a=4 -> a[3:2]=01, b=0 -> b[1]=0
        step(1'b1, 1'b1, 4'd4, 4'd0);
        chk_all("p1gt", 1'b1, 2'd1, 8'd3);
        // Extremes: max a vs zero b, zero a vs max b (b[1]=1 blocks P1)
        step(1'b1, 1'b1, 4'd15, 4'd0);
`ifdef TEST_STICKY_STATUS_EN
        chk_all("gtmax", 1'b1, 2'd3, 8'd3);
`else
        chk_all("gtmax", 1'b0, 2'd3, 8'd3);
`endif
        step(1'b1, 1'b1, 4'd0, 4'd15);
`ifdef TEST_STICKY_STATUS_EN
        chk_all("ltmax", 1'b1, 2'd0, 8'd3);
`else
        chk_all("ltmax", 1'b0, 2'd0, 8'd3);
`endif

        // Saturation: from 3, 252 more hits reach 255, then it must stick.
        for (int i = 0; i < 251; i++) step(1'b1, 1'b1, 4'd8, 4'd8);
        chk("sat.254", {24'd0, bus.hit_cnt}, 32'd254);
        step(1'b1, 1'b1, 4'd8, 4'd8);
        chk("sat.255", {24'd0, bus.hit_cnt}, 32'd255);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 4'd8, 4'd8);
        chk_all("sat.hold", 1'b1, 2'd2, 8'd255);

        // Mid-operation reset clears everything on that edge.
        step(1'b0, 1'b1, 4'd8, 4'd8);
        chk_all("midrst", 1'b0, 2'd0, 8'd0);
        step(1'b1, 1'b1, 4'd8, 4'd8);
        chk_all("post.eq", 1'b1, 2'd2, 8'd1);
        step(1'b1, 1'b1, 4'd10, 4'd8);
`ifdef TEST_STICKY_STATUS_EN
        chk_all("post.gt", 1'b1, 2'd3, 8'd1);
`else
        chk_all("post.gt", 1'b0, 2'd3, 8'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_test
`default_nettype wire

// File: doc/test.md
Name: test

Overview:
- Registered priority if-chain classifier comparing two 4-bit operands `a` and `b`.
- Each accepted cycle produces a 1-bit `status` flag, a 2-bit rule code and a saturating count of status hits.
- Used as a small control/status decoder.
- Serves as the reference target for if/else-chain translation checks.

Parameters:
- W, 4, operand width of `a`/`b`; must be >= 4 because rule P1 uses bits 3:1.
- CNT_W, 8, width of the status-hit counter.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rstn  in  1  reset, synchronous and active-low.
- in_valid  in  1  qualifies `a`/`b` this cycle.
- a  in  W  operand A, unsigned.
- b  in  W  operand B, unsigned.
- status  out  1  registered flag; 1 when the winning rule is P1 or P2.
- code  out  2  registered index of the winning rule.
- hit_cnt  out  CNT_W  saturating count of accepted cycles with status=1.

Behaviour:
- Clocking and reset:
  - One clock, `clk`.
  - Reset is synchronous and active-low: when `rstn`=0 at a rising edge, status=0, code=2'd0, hit_cnt=0.
  - Reset has priority over everything else, including a cycle where in_valid=1.
- Latency: an accepted input (in_valid=1 at edge N) updates all outputs at edge N; they are visible after that edge (1-cycle latency).
- Hold: when in_valid=0, all outputs hold their previous values.
- Priority chain, evaluated on an accepted cycle; the first match wins:
  - P1: {b[1], a[3:2]} == 3'b001 → status=1, code=2'd1.
  - P2: a == b → status=1, code=2'd2.
  - P3: a > b (unsigned, full W bits) → status=0, code=2'd3.
  - Else (a < b, no P1) → status=0, code=2'd0.
- Overlap rule: if both P1 and P2 hold (e.g. a=b=4'b0101), P1 wins and code=1.
- hit_cnt:
  - Increments by 1 on each accepted cycle whose new status is 1.
  - Saturates at 2^CNT_W-1; it never wraps.
- Outputs are fully registered; there is no combinational path from inputs to outputs.
- Unknown (X) inputs are only sampled when in_valid=1. The bench must keep in_valid=0 until a and b are driven.

Optional Feature:
- Macro: TEST_STICKY_STATUS_EN.
- Defined: status is sticky. Once it is set to 1 by an accepted P1/P2 cycle, it stays 1 until reset, even if later cycles match P3/else. code and hit_cnt still update normally.
- Undefined: status is recomputed on every accepted cycle as specified above.

Decomposition:
- Shared package `test_pkg` holds:
  - 2-bit code constants CODE_NONE=0, CODE_P1=1, CODE_EQ=2, CODE_GT=3.
  - Default widths W=4 and CNT_W=8.
- One natural sub-module, `test_classify`: purely combinational. It takes a and b and returns the next status and code.
- Top `test` contains the registers, the in_valid hold logic, the counter and the sticky option.

Test Plan:
- Reset: hold rstn=0 for 2 edges with in_valid=1, a=4'd5, b=4'd5 → status=0, code=0, hit_cnt=0 after each edge.
- GT case: rstn=1, in_valid=1, a=10, b=8 → after 1 edge status=0, code=3, hit_cnt=0.
- P1 vs P2 priority: a=4'b0101, b=4'b0101 → status=1, code=1, hit_cnt=1. Then a=8, b=8 → status=1, code=2, hit_cnt=2.
- Else and hold:
  - a=2, b=9 → status=0, code=0.
  - Then in_valid=0 with a=b=8 for 3 edges → outputs unchanged, hit_cnt unchanged.
- Saturation: with CNT_W=8, drive a=b=8 for 260 accepted cycles → hit_cnt stops at 255.
- Mid-operation reset: pulse rstn=0 for 1 edge → outputs clear at that edge. With TEST_STICKY_STATUS_EN, a=b=8 then a=10, b=8 → status stays 1 and code=3.
